// File: rtl/debounce_edge.sv
// Glitch filter and edge detector for asynchronous level inputs: synchronizes serial_i,
// accepts a new level only after thresh_i consecutive mismatching cycles, and emits pulses.

module sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic serial_i,
    output logic serial_o
);

    logic [STAGES-1:0] sync_d;
    logic [STAGES-1:0] sync_q;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], serial_i};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign serial_o = sync_q[STAGES-1];

endmodule

module debounce_edge #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             serial_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] thresh_i,
    output logic             level_o,
    output logic             r_edge_o,
    output logic             f_edge_o,
    output logic             glitch_o
);

    logic s;

    logic             level_d,  level_q;
    logic [CNT_W-1:0] cnt_d,    cnt_q;
    logic             r_edge_d, r_edge_q;
    logic             f_edge_d, f_edge_q;
    logic             glitch_d, glitch_q;

    // One bit wider than the counter so cnt + 1 never wraps before the compare.
    logic [CNT_W:0] th_eff;
    logic [CNT_W:0] cnt_inc;

    sync #(
        .STAGES (STAGES)
    ) u_sync (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .serial_i (serial_i),
        .serial_o (s)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path through this block infers a latch.
        level_d  = level_q;
        cnt_d    = cnt_q;
        r_edge_d = 1'b0;
        f_edge_d = 1'b0;
        glitch_d = 1'b0;

        th_eff  = (thresh_i == '0) ? (CNT_W+1)'(1) : {1'b0, thresh_i};
        cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

        if (!en_i) begin
            // Disabling discards a partial run silently rather than calling it a glitch.
            cnt_d = '0;
        end else if (s == level_q) begin
            if (cnt_q != '0) begin
                cnt_d    = '0;
                glitch_d = 1'b1;
            end
        end else if (cnt_inc >= th_eff) begin
            level_d  = s;
            cnt_d    = '0;
            r_edge_d = s;
            f_edge_d = ~s;
        end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q  <= 1'b0;
            cnt_q    <= '0;
            r_edge_q <= 1'b0;
            f_edge_q <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            r_edge_q <= r_edge_d;
            f_edge_q <= f_edge_d;
            glitch_q <= glitch_d;
        end
    end

    assign level_o  = level_q;
    assign r_edge_o = r_edge_q;
    assign f_edge_o = f_edge_q;
    assign glitch_o = glitch_q;

endmodule

// File: tb/tb_debounce_edge.sv
// Directed bench for debounce_edge (STAGES=2, CNT_W=16): latency, glitch rejection,
// threshold 0/1 equivalence, mid-run threshold change, enable gating and async reset.

module tb_debounce_edge;

    localparam int CNT_W = 16;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             serial_i;
    logic             en_i;
    logic [CNT_W-1:0] thresh_i;
    logic             level_o;
    logic             r_edge_o;
    logic             f_edge_o;
    logic             glitch_o;

    int total = 0;
    int bad   = 0;

    logic [23:0] lv_a, re_a, fe_a;
    logic [23:0] lv_b, re_b, fe_b;

    debounce_edge #(
        .STAGES (2),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .serial_i (serial_i),
        .en_i     (en_i),
        .thresh_i (thresh_i),
        .level_o  (level_o),
        .r_edge_o (r_edge_o),
        .f_edge_o (f_edge_o),
        .glitch_o (glitch_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic sq(input int k);
        return (k >= 0) && ((k % 6) < 3);
    endfunction

    // Reset with serial_i at val; returns on a negedge, so the next posedge is edge 0.
    task automatic do_reset(input logic val);
        @(negedge clk_i);
        rst_ni   = 1'b0;
        serial_i = val;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset;
        en_i     = 1'b1;
        thresh_i = 16'd4;
        serial_i = 1'b1;
        rst_ni   = 1'b0;
        #1;
        total++;
        if ({level_o, r_edge_o, f_edge_o, glitch_o} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0000", {level_o, r_edge_o, f_edge_o, glitch_o});
        end
        do_reset(1'b1);
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk_i);
            total++;
            if (level_o !== (i >= 5)) begin
                bad++;
                $display("FAIL reset_level edge %0d: got %b want %b", i, level_o, (i >= 5));
            end
            total++;
            if (r_edge_o !== (i == 5)) begin
                bad++;
                $display("FAIL reset_redge edge %0d: got %b want %b", i, r_edge_o, (i == 5));
            end
            total++;
            if (glitch_o !== 1'b0) begin
                bad++;
                $display("FAIL reset_glitch edge %0d: got %b want 0", i, glitch_o);
            end
        end
    endtask

    task automatic test_glitch;
        int n_glitch;
        n_glitch = 0;
        thresh_i = 16'd4;
        do_reset(1'b0);
        repeat (2) @(negedge clk_i);
        for (int k = 0; k <= 8; k++) begin
            if (k == 0) serial_i = 1'b1;
            if (k == 2) serial_i = 1'b0;
            @(negedge clk_i);
            if (glitch_o === 1'b1) n_glitch++;
            total++;
            if (glitch_o !== (k == 4)) begin
                bad++;
                $display("FAIL glitch_pulse edge %0d: got %b want %b", k, glitch_o, (k == 4));
            end
            total++;
            if ({level_o, r_edge_o, f_edge_o} !== 3'b000) begin
                bad++;
                $display("FAIL glitch_level edge %0d: got %b want 000", k, {level_o, r_edge_o, f_edge_o});
            end
        end
        total++;
        if (n_glitch != 1) begin
            bad++;
            $display("FAIL glitch_count: got %0d want 1", n_glitch);
        end
    endtask

    task automatic run_square(input logic [CNT_W-1:0] th, output logic [23:0] lv,
                              output logic [23:0] re, output logic [23:0] fe);
        int n_r, n_f;
        n_r = 0;
        n_f = 0;
        lv = '0;
        re = '0;
        fe = '0;
        thresh_i = th;
        do_reset(1'b0);
        for (int k = 0; k < 24; k++) begin
            serial_i = sq(k);
            @(negedge clk_i);
            lv[k] = level_o;
            re[k] = r_edge_o;
            fe[k] = f_edge_o;
            if (r_edge_o === 1'b1) n_r++;
            if (f_edge_o === 1'b1) n_f++;
            total++;
            if (level_o !== sq(k - 2)) begin
                bad++;
                $display("FAIL square_level th=%0d edge %0d: got %b want %b", th, k, level_o, sq(k - 2));
            end
            total++;
            if (r_edge_o !== (sq(k - 2) && !sq(k - 3))) begin
                bad++;
                $display("FAIL square_redge th=%0d edge %0d: got %b want %b", th, k, r_edge_o,
                         (sq(k - 2) && !sq(k - 3)));
            end
            total++;
            if (f_edge_o !== (!sq(k - 2) && sq(k - 3))) begin
                bad++;
                $display("FAIL square_fedge th=%0d edge %0d: got %b want %b", th, k, f_edge_o,
                         (!sq(k - 2) && sq(k - 3)));
            end
        end
        total++;
        if (n_r != 4 || n_f != 4) begin
            bad++;
            $display("FAIL square_counts th=%0d: got r=%0d f=%0d want r=4 f=4", th, n_r, n_f);
        end
    endtask

    task automatic test_thresh_zero;
        run_square(16'd1, lv_a, re_a, fe_a);
        run_square(16'd0, lv_b, re_b, fe_b);
        total++;
        if ({lv_b, re_b, fe_b} !== {lv_a, re_a, fe_a}) begin
            bad++;
            $display("FAIL thresh0_vs_1: got %h want %h", {lv_b, re_b, fe_b}, {lv_a, re_a, fe_a});
        end
    endtask

    task automatic test_thresh_drop;
        thresh_i = 16'd10;
        do_reset(1'b0);
        repeat (2) @(negedge clk_i);
        for (int k = 0; k <= 7; k++) begin
            if (k == 0) serial_i = 1'b1;
            if (k == 7) thresh_i = 16'd3;
            @(negedge clk_i);
            if (k == 6) begin
                total++;
                if (dut.cnt_q !== 16'd5) begin
                    bad++;
                    $display("FAIL drop_cnt_before: got %0d want 5", dut.cnt_q);
                end
            end
            total++;
            if (level_o !== (k == 7)) begin
                bad++;
                $display("FAIL drop_level edge %0d: got %b want %b", k, level_o, (k == 7));
            end
        end
        total++;
        if (r_edge_o !== 1'b1 || dut.cnt_q !== 16'd0) begin
            bad++;
            $display("FAIL drop_accept: got redge=%b cnt=%0d want redge=1 cnt=0", r_edge_o, dut.cnt_q);
        end
    endtask

    task automatic test_enable;
        thresh_i = 16'd6;
        en_i     = 1'b1;
        do_reset(1'b0);
        repeat (2) @(negedge clk_i);
        for (int k = 0; k <= 13; k++) begin
            if (k == 0) serial_i = 1'b1;
            if (k == 5) en_i = 1'b0;
            if (k == 7) en_i = 1'b1;
            @(negedge clk_i);
            if (k == 4 || k == 6) begin
                total++;
                if (dut.cnt_q !== ((k == 4) ? 16'd3 : 16'd0)) begin
                    bad++;
                    $display("FAIL enable_cnt edge %0d: got %0d want %0d", k, dut.cnt_q,
                             (k == 4) ? 3 : 0);
                end
            end
            total++;
            if (glitch_o !== 1'b0) begin
                bad++;
                $display("FAIL enable_glitch edge %0d: got %b want 0", k, glitch_o);
            end
            total++;
            if ({level_o, r_edge_o} !== {(k >= 12), (k == 12)}) begin
                bad++;
                $display("FAIL enable_accept edge %0d: got %b want %b", k, {level_o, r_edge_o},
                         {(k >= 12), (k == 12)});
            end
        end
    endtask

    task automatic test_async_reset;
        // Enters with level_o=1, serial_i=1; start a falling run so a partial count exists.
        thresh_i = 16'd8;
        serial_i = 1'b0;
        repeat (5) @(negedge clk_i);
        total++;
        if (level_o !== 1'b1 || dut.cnt_q === 16'd0) begin
            bad++;
            $display("FAIL async_prerun: got level=%b cnt=%0d want level=1 cnt>0", level_o, dut.cnt_q);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        total++;
        if ({level_o, r_edge_o, f_edge_o, glitch_o} !== 4'b0000 || dut.cnt_q !== 16'd0) begin
            bad++;
            $display("FAIL async_clear: got %b cnt=%0d want 0000 cnt=0",
                     {level_o, r_edge_o, f_edge_o, glitch_o}, dut.cnt_q);
        end
        serial_i = 1'b1;
        thresh_i = 16'd4;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk_i);
            total++;
            if ({level_o, r_edge_o} !== {(k >= 5), (k == 5)}) begin
                bad++;
                $display("FAIL async_release edge %0d: got %b want %b", k, {level_o, r_edge_o},
                         {(k >= 5), (k == 5)});
            end
        end
    endtask

    initial begin
        rst_ni   = 1'b0;
        serial_i = 1'b0;
        en_i     = 1'b1;
        thresh_i = '0;
        test_reset();
        test_glitch();
        test_thresh_zero();
        test_thresh_drop();
        test_enable();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debounce_edge.md
# debounce_edge

Glitch filter and edge detector for asynchronous level inputs such as pads, external interrupts and GPIO. It sits directly downstream of the `sync` synchronizer and instantiates it internally. It qualifies the synchronized level against a programmable stability threshold. It outputs a filtered level, single-cycle rising and falling edge pulses, and a glitch-reject pulse, all registered in the `clk_i` domain.

## Interface
Parameters:
- STAGES, default 2: synchronizer depth, passed unchanged to the internal `sync` instance; must be ≥ 2.
- CNT_W, default 16: width of the threshold input and of the internal stability counter.

Ports:
- clk_i  in  1  clock; all state is in this domain.
- rst_ni  in  1  reset, asynchronous, active-low.
- serial_i  in  1  raw asynchronous input level.
- en_i  in  1  filter enable, synchronous to `clk_i`.
- thresh_i  in  CNT_W  number of consecutive mismatching cycles needed to accept a new level; 0 behaves as 1.
- level_o  out  1  filtered, debounced level.
- r_edge_o  out  1  one-cycle pulse when `level_o` rises.
- f_edge_o  out  1  one-cycle pulse when `level_o` falls.
- glitch_o  out  1  one-cycle pulse when a mismatch run aborts before reaching the threshold.

## Operation
- The internal signal `s` is the output of `sync #(STAGES)` driven by `serial_i`. No other path from `serial_i` exists.
- State consists of `level_q`, which drives `level_o`, and an unsigned counter `cnt` of CNT_W bits. The edge and glitch outputs are registered flops.
- Effective threshold: `th = (thresh_i == 0) ? 1 : thresh_i`. `thresh_i` is sampled every cycle and is not latched.
- Per rising edge of `clk_i`, first matching rule wins:
  - `en_i == 0`: `cnt <= 0`, `level_q` held, all pulses 0. No glitch is reported even if `cnt > 0`.
  - `s == level_q` and `cnt > 0`: `cnt <= 0`, `glitch_o <= 1`.
  - `s == level_q` and `cnt == 0`: hold.
  - `s != level_q` and `cnt + 1 >= th`: `level_q <= s`, `cnt <= 0`. Set `r_edge_o <= s` and `f_edge_o <= !s`.
  - `s != level_q` otherwise: `cnt <= cnt + 1`.
- Compute `cnt + 1` at CNT_W+1 bits so the comparison never wraps. `cnt` never exceeds `th - 1`, so no saturation logic is needed.
- If `thresh_i` drops below `cnt + 1` mid-run, the level is accepted on the next mismatching cycle. If it rises, the run simply continues.
- `r_edge_o`, `f_edge_o` and `glitch_o` are mutually exclusive and never asserted for two consecutive cycles from the same run.
- An edge pulse is asserted in the same cycle that `level_o` first shows the new value.

## Timing
- Reset values: `level_o = 0`, `r_edge_o = 0`, `f_edge_o = 0`, `glitch_o = 0`, `cnt = 0`. The sync stages are also cleared.
- Reset is asynchronous on assertion and takes effect mid-run, discarding any partial count. After release, a high `serial_i` produces a rising edge after the normal latency.
- Latency: let `serial_i` change and stay stable, first sampled at clock edge N. Then `level_o` and the edge pulse appear after edge `N + STAGES + th - 1`.
  - Example: STAGES=2, th=1 gives edge N+2, 3 edges counting edge N.
- Minimum accepted pulse width is `th` clock cycles at `s`. Shorter runs produce `glitch_o` one cycle after `s` returns.
- Each output pulse lasts exactly 1 cycle.
- `en_i` takes effect at the next edge, with no latency beyond that.

## Test plan
- Reset, STAGES=2, thresh_i=4, `serial_i` held 1 from reset release (edge 0):
  - `level_o` and `r_edge_o` go 1 after edge 5.
  - `r_edge_o` is 0 again after edge 6.
  - `glitch_o` stays 0.
- thresh_i=4 with a 2-cycle high pulse on `serial_i`:
  - `level_o` stays 0.
  - Exactly one `glitch_o` pulse occurs 2 cycles after the pulse reaches `s`.
- thresh_i=0 versus thresh_i=1, square wave of period 6 cycles:
  - Identical waveforms in both cases.
  - `level_o` tracks `s` one edge late.
  - `r_edge_o` and `f_edge_o` alternate, one pulse each per period.
- Run in progress with `cnt=5` and thresh_i=10; change `thresh_i` to 3 while the mismatch persists:
  - `level_o` toggles at the next edge with an edge pulse.
  - `cnt` returns to 0.
- Mismatch run with `cnt=3`, then `en_i` set to 0 for 2 cycles, then back to 1 with `s` still mismatching:
  - No glitch pulse.
  - The count restarts from 0, so acceptance occurs th cycles after re-enable.
- `rst_ni` asserted asynchronously mid-run while `level_o=1`:
  - All outputs go 0 immediately, without waiting for a clock edge.
  - After release with `serial_i=1`, `r_edge_o` fires after `STAGES + th` edges.
